// File: rtl/phase_unwrapper_if.sv
// rtl/phase_unwrapper_if.sv - sample and result signals between the CORDIC phase stage and the unwrapper
interface phase_unwrapper_if #(
  parameter int BIT_WIDTH = 24,
  parameter int TURN_BITS = 8
);
  localparam int OUT_W = BIT_WIDTH + TURN_BITS;

  logic signed [BIT_WIDTH-1:0] phi_i;
  logic                        valid_i;
  logic                        rezero_i;
  logic signed [OUT_W-1:0]     unwrapped_o;
  logic                        unwrapped_valid_o;
  logic signed [OUT_W-1:0]     avg_o;
  logic                        avg_valid_o;
  logic                        sat_o;

  modport master (
    output phi_i, valid_i, rezero_i,
    input  unwrapped_o, unwrapped_valid_o, avg_o, avg_valid_o, sat_o
  );

  modport slave (
    input  phi_i, valid_i, rezero_i,
    output unwrapped_o, unwrapped_valid_o, avg_o, avg_valid_o, sat_o
  );
endinterface

// File: rtl/phase_unwrapper.sv
// rtl/phase_unwrapper.sv - turns wrapped CORDIC phase into a continuous phase plus a block average
module phase_unwrapper #(
  parameter int BIT_WIDTH = 24,
  parameter int TURN_BITS = 8,
  parameter int LOG2_AVG  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  phase_unwrapper_if.slave  bus
);
  localparam int OUT_W = BIT_WIDTH + TURN_BITS;
  localparam int ACC_W = OUT_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  state_t                      state_q, state_d;
  logic signed [BIT_WIDTH-1:0] prev_q, prev_d;
  logic signed [BIT_WIDTH-1:0] delta;
  logic signed [OUT_W:0]       sum_wide;
  logic signed [OUT_W-1:0]     unwr_q, unwr_d;
  logic                        uv_q;
  logic                        restart_q, restart_d;
  logic                        sat_q, sat_d;
  logic                        pend_q, pend_d;

  logic signed [ACC_W-1:0]     acc_q, acc_base, acc_sum, avg_shift;
  logic [CNT_W-1:0]            cnt_q, cnt_base;
  logic signed [OUT_W-1:0]     avg_q;
  logic                        avg_valid_q;

  // Next-state and unwrap arithmetic: a half-turn step wraps to the negative code by two's complement truncation
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    unwr_d    = unwr_q;
    sat_d     = sat_q;
    pend_d    = pend_q | bus.rezero_i;
    restart_d = 1'b0;
    delta     = bus.phi_i - prev_q;
    sum_wide  = (OUT_W+1)'(unwr_q) + (OUT_W+1)'(delta);
    if (bus.valid_i) begin
      prev_d = bus.phi_i;
      if (state_q == ST_INIT || pend_q || bus.rezero_i) begin
        unwr_d    = OUT_W'(bus.phi_i);
        state_d   = ST_TRACK;
        pend_d    = 1'b0;
        sat_d     = 1'b0;
        restart_d = 1'b1;
      end else if (sum_wide[OUT_W] != sum_wide[OUT_W-1]) begin
        unwr_d = sum_wide[OUT_W] ? OUT_MIN : OUT_MAX;
        sat_d  = 1'b1;
      end else begin
        unwr_d = sum_wide[OUT_W-1:0];
      end
    end
  end

  // State register and unwrapped output stage, one cycle after the accepted sample
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INIT;
      prev_q    <= '0;
      unwr_q    <= '0;
      uv_q      <= 1'b0;
      restart_q <= 1'b0;
      sat_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      unwr_q    <= unwr_d;
      uv_q      <= bus.valid_i;
      restart_q <= restart_d;
      sat_q     <= sat_d;
      pend_q    <= pend_d;
    end
  end

  // A re-initialised sample starts a fresh block, so it sees an empty accumulator
  always_comb begin
    acc_base  = restart_q ? '0 : acc_q;
    cnt_base  = restart_q ? '0 : cnt_q;
    acc_sum   = acc_base + ACC_W'(unwr_q);
    avg_shift = acc_sum >>> LOG2_AVG;
  end

  // Block averager fed by the registered unwrapped value; reloads without a gap on the last sample
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (uv_q) begin
        if (cnt_base == CNT_LAST) begin
          avg_q       <= avg_shift[OUT_W-1:0];
          avg_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_base + CNT_W'(1);
        end
      end
    end
  end

  assign bus.unwrapped_o       = unwr_q;
  assign bus.unwrapped_valid_o = uv_q;
  assign bus.avg_o             = avg_q;
  assign bus.avg_valid_o       = avg_valid_q;
  assign bus.sat_o             = sat_q;
endmodule

// File: tb/tb_phase_unwrapper.sv
// tb/tb_phase_unwrapper.sv - directed vectors for phase_unwrapper
module tb_phase_unwrapper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  phase_unwrapper_if #(.BIT_WIDTH(24), .TURN_BITS(8)) if0 ();
  phase_unwrapper_if #(.BIT_WIDTH(24), .TURN_BITS(2)) if1 ();

  phase_unwrapper #(.BIT_WIDTH(24), .TURN_BITS(8), .LOG2_AVG(2)) u0 (
    .clk_i(clk), .rst_i(rst), .bus(if0)
  );
  phase_unwrapper #(.BIT_WIDTH(24), .TURN_BITS(2), .LOG2_AVG(2)) u1 (
    .clk_i(clk), .rst_i(rst), .bus(if1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic [23:0] phi, input logic v, input logic rz);
    if0.phi_i = phi; if0.valid_i = v; if0.rezero_i = rz;
    @(negedge clk);
  endtask

  task automatic drive1(input logic [23:0] phi, input logic v, input logic rz);
    if1.phi_i = phi; if1.valid_i = v; if1.rezero_i = rz;
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic [31:0] avg_seen;
    if0.phi_i = '0; if0.valid_i = 1'b0; if0.rezero_i = 1'b0;
    if1.phi_i = '0; if1.valid_i = 1'b0; if1.rezero_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_unwr", $unsigned(if0.unwrapped_o), 32'h0);
    check("rst_uv", if0.unwrapped_valid_o, 1'b0);
    check("rst_avg", $unsigned(if0.avg_o), 32'h0);
    check("rst_sat", if0.sat_o, 1'b0);

    drive0(24'h100000, 1'b1, 1'b0);
    check("first_unwr", $unsigned(if0.unwrapped_o), 32'h00100000);
    check("first_uv", if0.unwrapped_valid_o, 1'b1);
    check("first_sat", if0.sat_o, 1'b0);
    drive0(24'h0, 1'b0, 1'b0);
    check("idle_uv", if0.unwrapped_valid_o, 1'b0);
    check("idle_hold", $unsigned(if0.unwrapped_o), 32'h00100000);

    drive0(24'h7F0000, 1'b1, 1'b0);
    check("fwd_7f", $unsigned(if0.unwrapped_o), 32'h007F0000);
    drive0(24'h810000, 1'b1, 1'b0);
    check("fwd_81", $unsigned(if0.unwrapped_o), 32'h00810000);
    drive0(24'hC10000, 1'b1, 1'b0);
    check("fwd_c1", $unsigned(if0.unwrapped_o), 32'h00C10000);
    drive0(24'h010000, 1'b1, 1'b0);
    check("fwd_turn", $unsigned(if0.unwrapped_o), 32'h01010000);

    drive0(24'h000000, 1'b1, 1'b1);
    check("rz_same_cycle", $unsigned(if0.unwrapped_o), 32'h0);
    drive0(24'h800000, 1'b1, 1'b0);
    check("half_turn_neg", $unsigned(if0.unwrapped_o), 32'hFF800000);
    check("half_turn_sat", if0.sat_o, 1'b0);
    drive0(24'h0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      drive1(24'(k * 32'h400000), 1'b1, 1'b0);
      if (k == 7) begin
        check("sat_below", $unsigned(if1.unwrapped_o), 26'h1C00000);
        check("sat_below_flag", if1.sat_o, 1'b0);
      end
    end
    check("sat_clamp", $unsigned(if1.unwrapped_o), 26'h1FFFFFF);
    check("sat_flag", if1.sat_o, 1'b1);
    drive1(24'h0, 1'b0, 1'b1);
    check("sat_held_rz_idle", if1.sat_o, 1'b1);
    drive1(24'h000010, 1'b1, 1'b0);
    check("rz_pending_unwr", $unsigned(if1.unwrapped_o), 26'h10);
    check("rz_pending_sat", if1.sat_o, 1'b0);
    drive1(24'h0, 1'b0, 1'b0);

    rst = 1'b1;
    drive0(24'h0, 1'b0, 1'b0);
    rst = 1'b0;
    drive0(24'd0, 1'b1, 1'b0);
    drive0(24'd4, 1'b1, 1'b0);
    drive0(24'd8, 1'b1, 1'b0);
    drive0(24'd12, 1'b1, 1'b0);
    check("avg_last_unwr", $unsigned(if0.unwrapped_o), 32'd12);
    check("avg_not_yet", if0.avg_valid_o, 1'b0);
    drive0(24'd0, 1'b1, 1'b0);
    check("avg_pulse", if0.avg_valid_o, 1'b1);
    check("avg_value", $unsigned(if0.avg_o), 32'd6);
    drive0(24'd0, 1'b1, 1'b0);
    check("avg_one_pulse", if0.avg_valid_o, 1'b0);
    check("avg_hold", $unsigned(if0.avg_o), 32'd6);
    drive0(24'd0, 1'b1, 1'b0);
    drive0(24'hFFFFFF, 1'b1, 1'b0);
    check("neg_unwr", $unsigned(if0.unwrapped_o), 32'hFFFFFFFF);
    drive0(24'h0, 1'b0, 1'b0);
    check("neg_avg_pulse", if0.avg_valid_o, 1'b1);
    check("neg_avg_value", $unsigned(if0.avg_o), 32'hFFFFFFFF);

    drive0(24'h20, 1'b1, 1'b0);
    drive0(24'h20, 1'b1, 1'b0);
    rst = 1'b1;
    drive0(24'h0, 1'b0, 1'b0);
    rst = 1'b0;
    check("midrst_unwr", $unsigned(if0.unwrapped_o), 32'h0);
    check("midrst_uv", if0.unwrapped_valid_o, 1'b0);
    check("midrst_avg", $unsigned(if0.avg_o), 32'h0);
    check("midrst_av", if0.avg_valid_o, 1'b0);
    pulses = 0;
    avg_seen = '0;
    for (int k = 0; k < 8; k++) begin
      drive0(24'h10, (k < 4), 1'b0);
      if (if0.avg_valid_o) begin
        pulses++;
        avg_seen = $unsigned(if0.avg_o);
      end
    end
    check("midrst_pulses", pulses, 1);
    check("midrst_avg_value", avg_seen, 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
